// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction-memory request/response and decode payload.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem read at a time, responses queued in a 2-entry FIFO.
// Latency: request issued 1 cycle after the IDLE decision; at most 1 instruction per 3 cycles.
// Backpressure: no request starts unless queue + outstanding < 2. Optional: INSTR_FETCH_ALIGN_CHECK_EN.
module instr_fetch (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        pc_addr,
  output logic               pc_advance,
  input  logic               flush,
  output logic               fetch_err,
  instr_fetch_if.master      bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t      state;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        outstanding;

  logic [31:0] q_data [2];
  logic [31:0] q_pc   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        start_ok;
  logic        misaligned;
  logic [31:0] fetch_addr;
  logic        push;
  logic        pop;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  assign misaligned = (pc_addr[1:0] != 2'b00);
  assign fetch_addr = pc_addr;
`else
  assign misaligned = 1'b0;
  assign fetch_addr = pc_addr & 32'hFFFF_FFFC;
`endif

  assign start_ok = (({1'b0, count} + {2'b00, outstanding}) < 3'd2) && !flush;

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign pc_advance    = imem_req_q & bus.imem_gnt & ~flush;

  assign bus.inst_valid = (count != 2'd0);
  assign bus.inst_data  = q_data[rd_ptr];
  assign bus.inst_pc    = q_pc[rd_ptr];

  // A response racing a flush is dropped, so push is qualified here.
  assign push = (state == WAIT) && bus.imem_rvalid && !flush;
  assign pop  = bus.inst_valid && bus.inst_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      outstanding <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok && !misaligned) begin
            state       <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_addr;
          end
        end
        REQ: begin
          if (flush) begin
            imem_req_q  <= 1'b0;
            outstanding <= bus.imem_gnt;
            state       <= bus.imem_gnt ? DRAIN : IDLE;
          end else if (bus.imem_gnt) begin
            imem_req_q  <= 1'b0;
            outstanding <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            outstanding <= 1'b0;
            state       <= IDLE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.imem_rvalid) begin
            outstanding <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= bus.imem_rdata;
        q_pc[wr_ptr]   <= imem_addr_q;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
  logic fetch_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_err_q <= 1'b0;
    end else if (state == IDLE && start_ok && misaligned) begin
      fetch_err_q <= 1'b1;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Port clk SHALL be: input, width 1, system clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, width 1, synchronous active-low reset.
REQ-004 Port pc_addr SHALL be: input, width 32, current PC value read from the PC register.
REQ-005 Port pc_advance SHALL be: output, width 1, one-cycle pulse telling next-PC logic that pc_addr was consumed.
REQ-006 Port imem_req SHALL be: output, width 1, instruction-memory read request.
REQ-007 Port imem_addr SHALL be: output, width 32, read address, held stable while imem_req=1.
REQ-008 Port imem_gnt SHALL be: input, width 1, memory accepts the request this cycle.
REQ-009 Port imem_rvalid SHALL be: input, width 1, read data valid.
REQ-010 Port imem_rdata SHALL be: input, width 32, instruction word.
REQ-011 Port flush SHALL be: input, width 1, discard all queued and in-flight fetches.
REQ-012 Ports inst_valid (output, 1), inst_data (output, 32) and inst_pc (output, 32) SHALL form the decode-side payload; inst_ready (input, 1) SHALL accept it.
REQ-013 Port fetch_err SHALL be: output, width 1, sticky misaligned-PC flag.

Function
REQ-014 FSM states SHALL be IDLE, REQ, WAIT and DRAIN.
REQ-015 IDLE -> REQ SHALL occur when queue count + outstanding < 2 and flush=0; on that edge imem_addr := pc_addr.
REQ-016 In REQ, imem_req=1; on imem_gnt=1 -> WAIT.
REQ-017 pc_advance SHALL equal imem_req & imem_gnt & ~flush, combinationally.
REQ-018 In WAIT, on imem_rvalid=1, {imem_rdata, imem_addr} SHALL be pushed to the queue -> IDLE; rvalid is never earlier than the cycle after gnt.
REQ-019 At most one request SHALL be outstanding; throughput is at most one instruction per 3 cycles.
REQ-020 The queue SHALL be a 2-entry FIFO: inst_valid = (count != 0); inst_data/inst_pc = head entry.
REQ-021 A pop SHALL occur when inst_valid & inst_ready; a simultaneous push and pop SHALL leave count unchanged.
REQ-022 A push to a full queue SHALL never occur, because REQ-015 guarantees space.
REQ-023 flush SHALL empty the queue at the next edge; inst_valid may still be 1 in the flush cycle, and the consumer ignores it.
REQ-024 flush in REQ with imem_gnt=0 SHALL give -> IDLE and drop imem_req.
REQ-025 flush in REQ with imem_gnt=1 SHALL give -> DRAIN.
REQ-026 flush in WAIT SHALL give -> DRAIN, or -> IDLE if imem_rvalid=1 in the same cycle, with the data discarded.
REQ-027 In DRAIN, imem_req=0; on imem_rvalid, the data SHALL be discarded -> IDLE; flush in DRAIN has no further effect.
REQ-028 flush in IDLE SHALL block the IDLE -> REQ transition for that cycle.

Reset
REQ-029 With rst_n=0 at an edge: state IDLE, queue count 0, outstanding 0, fetch_err 0.
REQ-030 After that edge: imem_req=0, imem_addr=0, inst_valid=0, inst_data=0, inst_pc=0, pc_advance=0.
REQ-031 Reset mid-transaction SHALL abandon any in-flight response; an imem_rvalid arriving after reset while in IDLE is ignored.
REQ-032 Reset SHALL take priority over flush and every other input.

Configuration
REQ-033 Macro INSTR_FETCH_ALIGN_CHECK_EN defined: if pc_addr[1:0] != 0 at the IDLE->REQ decision, no request SHALL be issued, the FSM stays IDLE, and fetch_err sets and holds until reset.
REQ-034 Macro INSTR_FETCH_ALIGN_CHECK_EN undefined: imem_addr SHALL be {pc_addr[31:2],2'b00} and fetch_err tied 0.

Verification
REQ-035 Scenario: reset, pc_addr=0x00000010, gnt on the first REQ cycle, rvalid 1 cycle later with rdata=0x20080005 -> pc_advance pulses once; inst_valid=1 with inst_data=0x20080005, inst_pc=0x10.
REQ-036 Scenario: inst_ready=0, memory always grants, addresses 0x0, 0x4, 0x8 -> exactly 2 entries queued, imem_req stays 0 thereafter; raising inst_ready pops 0x0, then 0x4, in order.
REQ-037 Scenario: flush asserted in the gnt cycle of address 0x40 -> pc_advance=0, state DRAIN, the following rvalid data is not enqueued, inst_valid=0 afterwards.
REQ-038 Scenario: flush during WAIT coincident with rvalid -> next state IDLE and the queue is empty.
REQ-039 Scenario: rst_n=0 asserted while in WAIT, then rvalid arrives -> all outputs 0 and no enqueue.
REQ-040 Scenario with INSTR_FETCH_ALIGN_CHECK_EN defined: pc_addr=0x00000006 -> fetch_err=1, imem_req never asserts; without the macro -> imem_addr=0x00000004.
